uart_loopback_ctrl: RTL and testbench

- Parametrised loopback/test controller placed between the uart block (FIFO-side interface) and the board I/O (button tick, LEDs, 4-digit seven-segment display).
- Pops received words and pushes transformed words back to the transmitter. Operates in manual (button) mode or one of two automatic modes.
- Maintains a parity-error counter and a received-word counter, and time-multiplexes status onto the display.

---
 rtl/uart_loopback_pkg.sv | 21 ++
 rtl/uart_loopback_ctrl_hex_to_sseg.sv | 16 +
 rtl/uart_loopback_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_loopback_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loopback_pkg.sv
// Shared encodings for the uart loopback controller.
// Mode codes, FSM state codes and the hex segment table.
package uart_loopback_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_ECHO   = 2'b01;
  localparam logic [1:0] MODE_INC    = 2'b10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] PUSH = 2'd2;

  // Active-low {g..a} patterns, index = hex digit.
  localparam logic [15:0][6:0] SSEG_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/uart_loopback_ctrl_hex_to_sseg.sv
// Nibble to active-low seven-segment pattern.
// Decimal point passes straight through as the MSB.
module hex_to_sseg
  import uart_loopback_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] sseg
);

  // Table lookup, dp on top.
  always_comb begin
    sseg = {dp, SSEG_TAB[hex]};
  end

endmodule

// File: rtl/uart_loopback_ctrl.sv
// Loopback controller between uart FIFOs and board I/O.
// Pops a word, transforms it, pushes it back; shows status.
module uart_loopback_ctrl
  import uart_loopback_pkg::*;
#(
  parameter int DW           = 8,
  parameter int INC          = 1,
  parameter int REFRESH_BITS = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic          btn_tick,
  input  logic          rx_empty,
  input  logic          tx_full,
  input  logic [DW-1:0] r_data,
  input  logic          err,
  output logic          rd_uart,
  output logic          wr_uart,
  output logic [DW-1:0] w_data,
  output logic [DW-1:0] led,
  output logic [3:0]    an,
  output logic [7:0]    sseg,
  output logic [15:0]   byte_cnt
);

  localparam logic [DW-1:0] INC_W = DW'(INC);

  logic [1:0]              state;
  logic [1:0]              mode_q;
  logic [7:0]              err_cnt;
  logic [REFRESH_BITS-1:0] refresh;
  logic                    st_idle;
  logic                    st_pop;
  logic                    st_push;
  logic                    auto_md;
  logic                    trigger;
  logic [1:0]              sel;
  logic [7:0]              led_x;
  logic [3:0]              nib;
  logic                    dp;

  assign st_idle = (state == IDLE);
  assign st_pop  = (state == POP);
  assign st_push = (state == PUSH);

  assign auto_md = (mode == MODE_ECHO) ||
                   (mode == MODE_INC);
  assign trigger = !rx_empty &&
                   (auto_md || btn_tick);

  assign rd_uart = st_pop;
  assign wr_uart = st_push && !tx_full;

  // Word FSM: trigger -> pop -> push until accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mode_q   <= MODE_MANUAL;
      w_data   <= '0;
      led      <= '0;
      byte_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (trigger) begin
            state  <= POP;
            mode_q <= mode;
          end
        end
        st_pop: begin
          led      <= r_data;
          byte_cnt <= byte_cnt + 16'd1;
          if (err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
          if (mode_q == MODE_ECHO)
            w_data <= r_data;
          else
            w_data <= r_data + INC_W;
          state <= PUSH;
        end
        st_push: begin
          if (!tx_full)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running display refresh counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      refresh <= '0;
    else
      refresh <= refresh + 1'b1;
  end

  assign sel   = refresh[REFRESH_BITS-1 -: 2];
  assign led_x = 8'(led);

  // Digit select: led nibbles, then error nibbles.
  always_comb begin
    an  = 4'b1111;
    nib = 4'h0;
    dp  = 1'b1;
    case (sel)
      2'd0: begin
        an  = 4'b1110;
        nib = led_x[3:0];
      end
      2'd1: begin
        an  = 4'b1101;
        nib = led_x[7:4];
        dp  = rx_empty;
      end
      2'd2: begin
        an  = 4'b1011;
        nib = err_cnt[3:0];
      end
      default: begin
        an  = 4'b0111;
        nib = err_cnt[7:4];
        dp  = tx_full;
      end
    endcase
  end

  hex_to_sseg u_sseg (
    .hex  (nib),
    .dp   (dp),
    .sseg (sseg)
  );

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Bench for uart_loopback_ctrl: FIFO environment,
// word-level reference model, directed and random traffic.
module tb_uart_loopback_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       btn_tick = 1'b0;
  logic       rx_empty = 1'b1;
  logic       tx_full = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       err = 1'b0;
  logic       rd_uart, wr_uart;
  logic [7:0] w_data, led;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [15:0] byte_cnt;

  logic       rx_empty7 = 1'b1;
  logic [6:0] r_data7 = 7'h7E;
  logic       rd7, wr7;
  logic [6:0] w7, led7;
  logic [3:0] an7;
  logic [7:0] sseg7;
  logic [15:0] bc7;

  uart_loopback_ctrl #(
    .DW(8), .INC(1), .REFRESH_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .btn_tick(btn_tick), .rx_empty(rx_empty),
    .tx_full(tx_full), .r_data(r_data), .err(err),
    .rd_uart(rd_uart), .wr_uart(wr_uart),
    .w_data(w_data), .led(led), .an(an),
    .sseg(sseg), .byte_cnt(byte_cnt)
  );

  uart_loopback_ctrl #(
    .DW(7), .INC(3), .REFRESH_BITS(18)
  ) dut7 (
    .clk(clk), .reset(reset), .mode(2'b10),
    .btn_tick(1'b0), .rx_empty(rx_empty7),
    .tx_full(1'b0), .r_data(r_data7), .err(1'b0),
    .rd_uart(rd7), .wr_uart(wr7),
    .w_data(w7), .led(led7), .an(an7),
    .sseg(sseg7), .byte_cnt(bc7)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Environment: receive FIFO contents {err,data}.
  logic [8:0] rxq[$];
  bit         popq = 0;
  int         push_pct = 0;
  int         n_rd = 0, n_wr = 0, cyc_n = 0;
  int         rd_at = 0, wr_at = 0;
  logic [7:0] last_w = 8'h00;

  // Reference model state (word-level view).
  bit         m_pop_due, m_owed;
  logic [1:0] m_mode;
  logic [7:0] m_led, m_val, m_errs;
  logic [15:0] m_cnt;
  logic [3:0] m_ref;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
    7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [3:0] an_tab [4] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  // Compare every cycle, then advance model one edge.
  always @(negedge clk) begin : mon
    logic [1:0] sel;
    logic [3:0] nib;
    logic       dpx;
    logic       e_wr;
    cyc_n++;
    if (!reset) begin
      m_pop_due = 0; m_owed = 0; m_mode = 0;
      m_led = 0; m_val = 0; m_errs = 0;
      m_cnt = 0; m_ref = 0;
      chk("rst_w_data", w_data, 8'h00);
    end
    sel = m_ref[3:2];
    dpx = 1'b1;
    case (sel)
      2'd0: nib = m_led[3:0];
      2'd1: begin nib = m_led[7:4]; dpx = rx_empty; end
      2'd2: nib = m_errs[3:0];
      default: begin nib = m_errs[7:4]; dpx = tx_full; end
    endcase
    e_wr = m_owed && !tx_full;
    chk("rd_uart", rd_uart, m_pop_due);
    chk("wr_uart", wr_uart, e_wr);
    if (e_wr) chk("w_data", w_data, m_val);
    chk("led", led, m_led);
    chk("byte_cnt", byte_cnt, m_cnt);
    chk("an", an, an_tab[sel]);
    chk("sseg", sseg, {dpx, seg_tab[nib]});
    if (rd_uart) begin
      n_rd++; popq = 1; rd_at = cyc_n;
    end
    if (wr_uart) begin
      n_wr++; last_w = w_data; wr_at = cyc_n;
    end
    if (reset) begin
      if (m_pop_due) begin
        m_led = r_data;
        m_cnt = m_cnt + 16'd1;
        if (err && m_errs != 8'hFF) m_errs++;
        m_val = (m_mode == 2'b01) ? r_data
                                  : r_data + 8'd1;
        m_owed = 1;
        m_pop_due = 0;
      end else if (m_owed && !tx_full) begin
        m_owed = 0;
      end else if (!m_owed && !rx_empty &&
                   (mode == 2'b01 || mode == 2'b10 ||
                    btn_tick)) begin
        m_pop_due = 1;
        m_mode = mode;
      end
      m_ref = m_ref + 4'd1;
    end
  end

  task automatic apply();
    rx_empty = (rxq.size() == 0);
    if (rxq.size() > 0) {err, r_data} = rxq[0];
    else {err, r_data} = 9'h000;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (popq) begin
      popq = 0;
      if (rxq.size() > 0) rxq.delete(0);
    end
    if (rxq.size() < 16 &&
        $urandom_range(99) < push_pct)
      rxq.push_back(9'($urandom));
    apply();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    btn_tick = 1'b0;
    rxq.delete();
    popq = 0;
    apply();
    repeat (3) cyc();
    reset = 1'b1;
  endtask

  initial begin
    int r0, w0, k;
    do_reset();
    chk("rst_an", an, 4'b1110);
    chk("rst_sseg", sseg, 8'hC0);

    // AUTO_INC single word 0x41.
    mode = 2'b10; tx_full = 1'b0;
    w0 = n_wr;
    rxq.push_back({1'b0, 8'h41}); apply();
    k = 0;
    while (n_wr == w0 && k < 10) begin cyc(); k++; end
    chk("inc_w", last_w, 8'h42);
    chk("inc_led", led, 8'h41);
    chk("inc_cnt", byte_cnt, 16'd1);
    chk("inc_lat", wr_at - rd_at, 1);

    // MANUAL: word waits for the button.
    mode = 2'b00;
    r0 = n_rd; w0 = n_wr;
    rxq.push_back({1'b0, 8'hFF}); apply();
    repeat (100) cyc();
    chk("man_idle_rd", n_rd - r0, 0);
    chk("man_idle_wr", n_wr - w0, 0);
    btn_tick = 1'b1; cyc(); btn_tick = 1'b0;
    repeat (8) cyc();
    chk("man_rd", n_rd - r0, 1);
    chk("man_wr", n_wr - w0, 1);
    chk("man_wrap", last_w, 8'h00);

    // AUTO_ECHO with transmitter back-pressure.
    mode = 2'b01; tx_full = 1'b1;
    r0 = n_rd; w0 = n_wr;
    rxq.push_back({1'b0, 8'h5A});
    rxq.push_back({1'b0, 8'h33}); apply();
    repeat (50) cyc();
    chk("echo_hold_rd", n_rd - r0, 1);
    chk("echo_hold_wr", n_wr - w0, 0);
    tx_full = 1'b0;
    k = 0;
    while (n_wr == w0 && k < 10) begin cyc(); k++; end
    chk("echo_w", last_w, 8'h5A);
    repeat (10) cyc();

    // Random traffic against the model.
    push_pct = 40;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(19) == 0)
        mode = 2'($urandom);
      tx_full = ($urandom_range(99) < 30);
      btn_tick = ($urandom_range(9) == 0);
      cyc();
    end
    push_pct = 0; btn_tick = 1'b0; tx_full = 1'b0;

    // 300 erroneous words: counter saturates.
    do_reset();
    mode = 2'b10;
    r0 = n_rd;
    for (int i = 0; i < 300; i++)
      rxq.push_back({1'b1, 8'(i)});
    apply();
    k = 0;
    while (n_rd - r0 < 300 && k < 1500) begin
      cyc(); k++;
    end
    chk("sat_cnt", byte_cnt, 16'd300);
    repeat (4) cyc();
    k = 0;
    do begin @(negedge clk); k++; end
    while (an !== 4'b0111 && k < 20);
    chk("sat_d3", {an, sseg}, {4'b0111, 8'h0E});
    k = 0;
    do begin @(negedge clk); k++; end
    while (an !== 4'b1011 && k < 20);
    chk("sat_d2", {an, sseg}, {4'b1011, 8'h8E});

    // Reset during PUSH aborts the word.
    mode = 2'b01; tx_full = 1'b1;
    r0 = n_rd; w0 = n_wr;
    rxq.push_back({1'b0, 8'hA5}); apply();
    k = 0;
    while (n_rd == r0 && k < 10) begin cyc(); k++; end
    reset = 1'b0; tx_full = 1'b0;
    rxq.delete(); popq = 0; apply();
    repeat (2) cyc();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rst_an_seq", an, an_tab[i / 4]);
    end
    chk("rst_led", led, 8'h00);
    chk("rst_cnt", byte_cnt, 16'd0);
    repeat (10) cyc();
    chk("rst_no_wr", n_wr - w0, 0);

    // DW=7, INC=3: 0x7E wraps to 0x01.
    rx_empty7 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!rd7 && k < 10);
    chk("d7_rd", rd7, 1'b1);
    @(posedge clk); #1;
    rx_empty7 = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!wr7 && k < 10);
    chk("d7_wr", wr7, 1'b1);
    chk("d7_w", w7, 7'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
